// File: rtl/riscv_defines.sv
// Shared RISC-V definitions: CSR operation encodings, counter CSR address map
// and mcountinhibit bit positions.
package riscv_defines;

    typedef enum logic [1:0] {
        CSR_OP_CSRRW = 2'b01,
        CSR_OP_CSRRS = 2'b10,
        CSR_OP_CSRRC = 2'b11
    } CsrOp_t;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT  = 12'h320,
        CSR_MHPMEVENT3     = 12'h323,
        CSR_MHPMEVENT31    = 12'h33F,
        CSR_MCYCLE         = 12'hB00,
        CSR_MINSTRET       = 12'hB02,
        CSR_MHPMCOUNTER3   = 12'hB03,
        CSR_MCYCLEH        = 12'hB80,
        CSR_MINSTRETH      = 12'hB82,
        CSR_MHPMCOUNTER3H  = 12'hB83,
        CSR_CYCLE          = 12'hC00,
        CSR_TIME           = 12'hC01,
        CSR_INSTRET        = 12'hC02,
        CSR_HPMCOUNTER3    = 12'hC03,
        CSR_CYCLEH         = 12'hC80,
        CSR_TIMEH          = 12'hC81,
        CSR_INSTRETH       = 12'hC82,
        CSR_HPMCOUNTER3H   = 12'hC83
    } CsrRegs_t;

    localparam int CSR_INHIBIT_CY = 0;
    localparam int CSR_INHIBIT_IR = 2;
    localparam int CSR_HPM_BASE   = 3;

    // Writable bits of mcountinhibit: CY, IR and one bit per implemented HPM.
    function automatic logic [31:0] inhibit_mask(input int num_hpm);
        logic [31:0] m;
        m = '0;
        m[CSR_INHIBIT_CY] = 1'b1;
        m[CSR_INHIBIT_IR] = 1'b1;
        for (int i = 0; i < num_hpm; i++) begin
            m[CSR_HPM_BASE + i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/csr_counter.sv
// One W-bit counter with independently writable 32-bit halves; a write in
// the same cycle as an increment wins and the increment is dropped.
module csr_counter
    import riscv_defines::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         inhibit,
    input  logic         we_lo,
    input  logic         we_hi,
    input  logic [31:0]  wdata,
    output logic [W-1:0] q
);

    logic [63:0] wide;

    // Merge the written half into a 64-bit view; bits at or above W fall away.
    always_comb begin
        wide = 64'(q);
        if (we_lo) wide[31:0]  = wdata;
        if (we_hi) wide[63:32] = wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (we_lo || we_hi) begin
            q <= wide[W-1:0];
        end else if (inc && !inhibit) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/csr_counter_unit.sv
// RISC-V counter/timer CSR group: combinational read of the pre-write value,
// CSRRW/RS/RC writes committed on the next edge, illegal-access detection.
module csr_counter_unit
    import riscv_defines::*;
#(
    parameter int NUM_HPM   = 4,
    parameter int CNT_WIDTH = 64,
    parameter int TIME_DIV  = 1
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 csr_valid,
    input  logic [11:0]                          csr_addr,
    input  CsrOp_t                               csr_op,
    input  logic [31:0]                          csr_wdata,
    input  logic                                 csr_wsrc_zero,
    input  logic                                 instr_retire,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    output logic [31:0]                          rdata,
    output logic                                 illegal
);

    localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

    logic [63:0] cnt_view [32];
    logic [31:0] inhibit_reg;
    logic [31:0] rd_val;
    logic [31:0] wval;
    logic [4:0]  idx;
    logic        hi;
    logic        ctr_range;
    logic        read_only;
    logic        in_map;
    logic        we_req;
    logic        commit;
    logic        cnt_wr;
    logic        inh_wr;
    logic        time_inc;

    assign idx       = csr_addr[4:0];
    assign hi        = csr_addr[7];
    assign ctr_range = (csr_addr[6:5] == 2'b00);
    assign read_only = (csr_addr[11:10] == 2'b11);

    always_comb begin
        in_map = 1'b0;
        rd_val = '0;
        // B01/B81 would alias the read-only time counter, so they stay unmapped.
        if (ctr_range && (csr_addr[11:8] == 4'hC || (csr_addr[11:8] == 4'hB && idx != 5'd1))) begin
            in_map = 1'b1;
            rd_val = hi ? cnt_view[idx][63:32] : cnt_view[idx][31:0];
        end else if (csr_addr == CSR_MCOUNTINHIBIT) begin
            in_map = 1'b1;
            rd_val = inhibit_reg;
        end else if (csr_addr >= CSR_MHPMEVENT3 && csr_addr <= CSR_MHPMEVENT31) begin
            in_map = 1'b1;
        end
    end

    always_comb begin
        case (csr_op)
            CSR_OP_CSRRW: wval = csr_wdata;
            CSR_OP_CSRRS: wval = rd_val | csr_wdata;
            CSR_OP_CSRRC: wval = rd_val & ~csr_wdata;
            default:      wval = rd_val;
        endcase
    end

    assign we_req  = csr_valid && (csr_op == CSR_OP_CSRRW || !csr_wsrc_zero);
    assign illegal = csr_valid && (!in_map || (read_only && we_req));
    assign rdata   = (csr_valid && in_map) ? rd_val : '0;
    assign commit  = we_req && !illegal;
    assign cnt_wr  = commit && (csr_addr[11:8] == 4'hB);
    assign inh_wr  = commit && (csr_addr == CSR_MCOUNTINHIBIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inhibit_reg <= '0;
        end else if (inh_wr) begin
            inhibit_reg <= wval & INH_MASK;
        end
    end

    if (TIME_DIV > 1) begin : g_presc
        localparam int PW = $clog2(TIME_DIV);
        logic [PW-1:0] presc_reg;
        assign time_inc = (presc_reg == PW'(TIME_DIV - 1));
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                presc_reg <= '0;
            end else if (time_inc) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end
        end
    end else begin : g_no_presc
        assign time_inc = 1'b1;
    end

    // Slot gi mirrors CSR index gi: 0 cycle, 1 time, 2 instret, 3.. HPMs.
    for (genvar gi = 0; gi < 32; gi++) begin : g_cnt
        if (gi < 3 + NUM_HPM) begin : g_impl
            logic                 inc;
            logic [CNT_WIDTH-1:0] q;
            if (gi == 0) begin : g_cycle
                assign inc = 1'b1;
            end else if (gi == 1) begin : g_time
                assign inc = time_inc;
            end else if (gi == 2) begin : g_instret
                assign inc = instr_retire;
            end else begin : g_hpm
                assign inc = hpm_event[gi-3];
            end
            csr_counter #(.W(CNT_WIDTH)) u_counter (
                .clk     (clk),
                .resetn  (resetn),
                .inc     (inc),
                .inhibit ((gi == 1) ? 1'b0 : inhibit_reg[gi]),
                .we_lo   ((gi != 1) && cnt_wr && !hi && idx == 5'(gi)),
                .we_hi   ((gi != 1) && cnt_wr && hi && idx == 5'(gi)),
                .wdata   (wval),
                .q       (q)
            );
            assign cnt_view[gi] = 64'(q);
        end else begin : g_none
            assign cnt_view[gi] = '0;
        end
    end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Scoreboard bench for csr_counter_unit (NUM_HPM=2, CNT_WIDTH=40, TIME_DIV=4)
// against an arithmetic model of the counter CSR rules.
module tb_csr_counter_unit;
    import riscv_defines::*;

    localparam int NH = 2;
    localparam int CW = 40;
    localparam int TD = 4;
    localparam logic [63:0] CMASK   = 64'h0000_00FF_FFFF_FFFF;
    localparam logic [31:0] INH_MSK = 32'h0000_001D;
    localparam int K_NONE = 0;
    localparam int K_CNT  = 1;
    localparam int K_INH  = 2;
    localparam int K_ZERO = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic          csr_valid;
    logic [11:0]   csr_addr;
    CsrOp_t        csr_op;
    logic [31:0]   csr_wdata;
    logic          csr_wsrc_zero;
    logic          instr_retire;
    logic [NH-1:0] hpm_event;
    logic [31:0]   rdata;
    logic          illegal;

    always #5 clk = ~clk;

    csr_counter_unit #(.NUM_HPM(NH), .CNT_WIDTH(CW), .TIME_DIV(TD)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .csr_valid     (csr_valid),
        .csr_addr      (csr_addr),
        .csr_op        (csr_op),
        .csr_wdata     (csr_wdata),
        .csr_wsrc_zero (csr_wsrc_zero),
        .instr_retire  (instr_retire),
        .hpm_event     (hpm_event),
        .rdata         (rdata),
        .illegal       (illegal)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] rdata;
        logic        illegal;
    } exp_t;

    exp_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] m_cnt [32];
    logic [31:0] m_inh;
    int          edges;

    logic [11:0] addr_tab [26] = '{12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC04, 12'hC05,
                                   12'hC80, 12'hC81, 12'hC82, 12'hC84, 12'hB00, 12'hB01,
                                   12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB80, 12'hB82,
                                   12'hB83, 12'hB84, 12'h320, 12'h321, 12'h323, 12'h33F,
                                   12'h7C0, 12'hC85};

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = '0;
        m_inh = '0;
        edges = 0;
    endtask

    // time is simply elapsed edges divided by the prescale ratio.
    function automatic logic [63:0] model_cnt(input int i);
        if (i == 1) return 64'(edges / TD);
        if (i == 0 || i == 2 || (i >= 3 && i < 3 + NH)) return m_cnt[i];
        return 64'h0;
    endfunction

    task automatic step(input bit v, input logic [11:0] a, input CsrOp_t op,
                        input logic [31:0] wd, input bit z, input bit ret,
                        input logic [NH-1:0] ev);
        int          ai;
        int          idx;
        int          kind;
        bit          hi;
        bit          ro;
        bit          we;
        bit          ill;
        bit          commit;
        logic [63:0] v64;
        logic [31:0] old;
        logic [31:0] wval;
        exp_t        e;
        csr_valid     = v;
        csr_addr      = a;
        csr_op        = op;
        csr_wdata     = wd;
        csr_wsrc_zero = z;
        instr_retire  = ret;
        hpm_event     = ev;
        ai   = int'(a);
        idx  = ai % 32;
        hi   = (ai % 256) >= 128;
        kind = K_NONE;
        ro   = 1'b0;
        if ((ai >= 'hC00 && ai <= 'hC1F) || (ai >= 'hC80 && ai <= 'hC9F)) begin
            kind = K_CNT;
            ro   = 1'b1;
        end else if (((ai >= 'hB00 && ai <= 'hB1F) || (ai >= 'hB80 && ai <= 'hB9F)) && idx != 1) begin
            kind = K_CNT;
        end else if (ai == 'h320) begin
            kind = K_INH;
        end else if (ai >= 'h323 && ai <= 'h33F) begin
            kind = K_ZERO;
        end
        old = 32'h0;
        if (kind == K_CNT) begin
            v64 = model_cnt(idx);
            old = hi ? v64[63:32] : v64[31:0];
        end else if (kind == K_INH) begin
            old = m_inh;
        end
        case (op)
            CSR_OP_CSRRW: wval = wd;
            CSR_OP_CSRRS: wval = old | wd;
            default:      wval = old & ~wd;
        endcase
        we     = v && (op == CSR_OP_CSRRW || !z);
        ill    = (kind == K_NONE) || (ro && we);
        commit = we && !ill;
        if (v) begin
            e.addr    = a;
            e.rdata   = old;
            e.illegal = ill;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (resetn) begin
            for (int i = 0; i < 3 + NH; i++) begin
                bit inc_i;
                if (i == 1) continue;
                if (i == 0)      inc_i = 1'b1;
                else if (i == 2) inc_i = ret;
                else             inc_i = ev[i-3];
                if (commit && kind == K_CNT && idx == i) begin
                    m_cnt[i] = (hi ? {wval, m_cnt[i][31:0]} : {m_cnt[i][63:32], wval}) & CMASK;
                end else if (inc_i && !m_inh[i]) begin
                    m_cnt[i] = (m_cnt[i] + 64'd1) & CMASK;
                end
            end
            if (commit && kind == K_INH) m_inh = wval & INH_MSK;
            edges++;
        end
    endtask

    task automatic pulse(input int n, input bit ret, input logic [NH-1:0] ev);
        for (int i = 0; i < n; i++) step(1'b0, 12'h000, CSR_OP_CSRRS, 32'h0, 1'b1, ret, ev);
    endtask

    task automatic rd(input logic [11:0] a);
        step(1'b1, a, CSR_OP_CSRRS, 32'h0, 1'b1, 1'b0, '0);
    endtask

    task automatic wr(input logic [11:0] a, input CsrOp_t op, input logic [31:0] d);
        step(1'b1, a, op, d, 1'b0, 1'b0, '0);
    endtask

    // Monitor: checks every presented transaction against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (csr_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_txn addr=%h rdata=%h illegal=%b", csr_addr, rdata, illegal);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e.rdata || illegal !== e.illegal) begin
                        n_fail++;
                        $display("FAIL txn addr=%h op=%0d got rdata=%h illegal=%b want rdata=%h illegal=%b",
                                 e.addr, csr_op, rdata, illegal, e.rdata, e.illegal);
                    end else begin
                        $display("[TB] txn addr=%h op=%0d rdata=%h illegal=%b ok",
                                 e.addr, csr_op, rdata, illegal);
                    end
                end
            end else begin
                n_tests++;
                if (rdata !== 32'h0 || illegal !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs got rdata=%h illegal=%b want rdata=0 illegal=0", rdata, illegal);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        model_reset();
        csr_valid = 1'b0; csr_addr = '0; csr_op = CSR_OP_CSRRS; csr_wdata = '0;
        csr_wsrc_zero = 1'b1; instr_retire = 1'b0; hpm_event = '0;
        repeat (2) @(posedge clk);
        #1;
        rd(12'hC00); rd(12'hC80); rd(12'h320);
        resetn = 1'b1;

        pulse(10, 1'b0, '0); rd(12'hC00); rd(12'hC80);
        wr(12'hB00, CSR_OP_CSRRW, 32'hFFFF_FFFF); pulse(1, 1'b0, '0);
        rd(12'hC80); rd(12'hC00);
        step(1'b1, 12'hB02, CSR_OP_CSRRW, 32'h0000_1234, 1'b0, 1'b1, '0); rd(12'hC02);

        wr(12'h320, CSR_OP_CSRRS, 32'h5); pulse(5, 1'b1, '0);
        rd(12'hB02); rd(12'hB00); rd(12'h320);
        wr(12'h320, CSR_OP_CSRRC, 32'h5); pulse(3, 1'b1, '0);
        rd(12'hB02); rd(12'hC00);
        wr(12'h320, CSR_OP_CSRRW, 32'hFFFF_FFFF); rd(12'h320);
        wr(12'h320, CSR_OP_CSRRW, 32'h0);

        wr(12'hC00, CSR_OP_CSRRW, 32'h1); rd(12'hC00);
        step(1'b1, 12'hC00, CSR_OP_CSRRS, 32'h0, 1'b1, 1'b0, '0);
        rd(12'h7C0); rd(12'hB01); rd(12'h321);

        pulse(3, 1'b0, 2'b10); rd(12'hC04); rd(12'hC03); rd(12'hC05);
        wr(12'hB05, CSR_OP_CSRRW, 32'h7); rd(12'hB05);
        wr(12'h323, CSR_OP_CSRRW, 32'h9); rd(12'h323);
        wr(12'hB80, CSR_OP_CSRRW, 32'hFFFF_FFFF); rd(12'hB80);
        rd(12'hC01); rd(12'hC81);

        for (int t = 0; t < 400; t++) begin
            logic [11:0] a;
            CsrOp_t      op;
            if ($urandom_range(0, 9) == 0) a = 12'($urandom);
            else                           a = addr_tab[$urandom_range(0, 25)];
            case ($urandom_range(0, 2))
                0:       op = CSR_OP_CSRRW;
                1:       op = CSR_OP_CSRRS;
                default: op = CSR_OP_CSRRC;
            endcase
            step($urandom_range(0, 3) != 0, a, op, $urandom, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), NH'($urandom));
        end

        // Asynchronous reset mid-operation, then the prescaled time check.
        resetn = 1'b0;
        model_reset();
        rd(12'hC00); rd(12'hB80); rd(12'h320);
        resetn = 1'b1;
        pulse(100, 1'b0, '0); rd(12'hC01); rd(12'hC00);
        pulse(2, 1'b0, '0);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
